// File: rtl/clkmon_pkg.sv
// Shared types, constants and helpers for the divided-clock monitor.
package clkmon_pkg;

  // IDLE waits for the first rising edge; MEAS measures rise-to-rise periods.
  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } clkmon_state_t;

  // A period longer than TIMEOUT_MULT expected periods is treated as a stopped clock.
  localparam int TIMEOUT_MULT = 4;

  // High time is acceptable when it is either half of an odd period (rounded down or up)
  // or exactly half of an even one.
  function automatic logic duty_ok(input int high, input int div);
    return (high == div / 2) || (high == (div + 1) / 2);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer for an asynchronous level plus a registered rising-edge detector.
// 'level' is the edge-detect flop, so it is time-aligned with 'rise':
// whenever rise=1, level=1 in the same cycle.
module sync_edge_det #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STG-1:0] sync_q;
  logic                sync;
  logic                sync_d;

  assign sync  = sync_q[SYNC_STG-1];
  assign level = sync_d;

  // Metastability chain: din enters at bit 0 and leaves at the top bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], din};
    end
  end

  // One extra flop for edge detection; the rise pulse itself is registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_d <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_d <= sync;
      rise   <= sync & ~sync_d;
    end
  end

endmodule

// File: rtl/clkdiv_monitor.sv
// Divided-clock checker: measures period and high time of clk_div in clk cycles,
// flags ratio/duty errors and reports lock after LOCK_CNT clean periods.
// Optional feature macro: CLKMON_TIMEOUT_EN (adds 'stuck' output and stopped-clock timeout).
// Handshake: meas_valid is a single-cycle strobe with no ready; period_cnt, high_cnt,
// ratio_err and duty_err are valid in that cycle and hold until the next strobe.
module clkdiv_monitor
  import clkmon_pkg::*;
#(
  parameter int DIV_EXP  = 7,
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4,
  parameter int SYNC_STG = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clk_div,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             ratio_err,
  output logic             duty_err,
  output logic             locked,
  output clkmon_state_t    state_dbg
`ifdef CLKMON_TIMEOUT_EN
  ,
  output logic             stuck
`endif
);

  localparam int GR_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DIV_VAL  = CNT_W'(DIV_EXP);
  localparam logic [GR_W-1:0]  LOCK_VAL = GR_W'(LOCK_CNT);
`ifdef CLKMON_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_MULT * DIV_EXP);
`endif

  clkmon_state_t    state_q, state_d;
  logic             level, rise;
  logic [CNT_W-1:0] cnt, hcnt;
  logic [GR_W-1:0]  good_run, good_inc;
  logic             meas_fire;
  logic             timeout_fire;
  logic             ratio_bad, duty_bad;

  sync_edge_det #(
    .SYNC_STG (SYNC_STG)
  ) u_sync (
    .clk   (clk),
    .rstn  (rstn),
    .din   (clk_div),
    .level (level),
    .rise  (rise)
  );

  assign state_dbg = state_q;
  assign ratio_bad = (cnt != DIV_VAL);
  assign duty_bad  = !duty_ok(int'(hcnt), DIV_EXP);
  assign good_inc  = (good_run == LOCK_VAL) ? good_run : good_run + 1'b1;

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and event strobes: first rise arms, later rises complete a measurement.
  always_comb begin
    state_d      = state_q;
    meas_fire    = 1'b0;
    timeout_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) state_d = MEAS;
      end
      MEAS: begin
        if (rise) begin
          meas_fire = 1'b1;
`ifdef CLKMON_TIMEOUT_EN
        end else if (cnt == TIMEOUT_VAL) begin
          timeout_fire = 1'b1;
          state_d      = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Period and high-time counters; a rise restarts both with the current (high) cycle counted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (rise) begin
      cnt  <= CNT_W'(1);
      hcnt <= CNT_W'(1);
    end else if (state_q == MEAS) begin
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (level && (hcnt != CNT_MAX)) hcnt <= hcnt + 1'b1;
    end
  end

  // Measurement outputs, error flags and lock tracking.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      period_cnt <= '0;
      high_cnt   <= '0;
      meas_valid <= 1'b0;
      ratio_err  <= 1'b0;
      duty_err   <= 1'b0;
      locked     <= 1'b0;
      good_run   <= '0;
`ifdef CLKMON_TIMEOUT_EN
      stuck      <= 1'b0;
`endif
    end else begin
      meas_valid <= meas_fire;
      if (meas_fire) begin
        period_cnt <= cnt;
        high_cnt   <= hcnt;
        ratio_err  <= ratio_bad;
        duty_err   <= duty_bad;
`ifdef CLKMON_TIMEOUT_EN
        stuck      <= 1'b0;
`endif
        if (ratio_bad || duty_bad) begin
          good_run <= '0;
          locked   <= 1'b0;
        end else begin
          good_run <= good_inc;
          locked   <= (good_inc == LOCK_VAL);
        end
      end else if (timeout_fire) begin
`ifdef CLKMON_TIMEOUT_EN
        stuck    <= 1'b1;
`endif
        locked   <= 1'b0;
        good_run <= '0;
      end
    end
  end

endmodule

// File: tb/tb_clkdiv_monitor.sv
// Bench for clkdiv_monitor: directed scenarios plus randomized clk_div waveforms,
// checked every cycle against a waveform-level reference model.
// Build with +define+CLKMON_TIMEOUT_EN to exercise the timeout feature.
module tb_clkdiv_monitor;

  localparam int DIV_EXP  = 7;
  localparam int CNT_W    = 8;
  localparam int LOCK_CNT = 4;
  localparam int LAT      = 3;   // sample-to-meas_valid latency for two sync stages
  localparam int TMO      = 4 * DIV_EXP;
  localparam int SAT      = 255;

  // ---------------- clock / reset ----------------
  logic clk = 0;
  logic rstn = 0;
  logic clk_div = 0;
  always #5 clk = ~clk;

  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic meas_valid, ratio_err, duty_err, locked, stuck_s;
  clkmon_pkg::clkmon_state_t state_dbg;

  clkdiv_monitor #(
    .DIV_EXP (DIV_EXP), .CNT_W (CNT_W), .LOCK_CNT (LOCK_CNT), .SYNC_STG (2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clk_div    (clk_div),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .meas_valid (meas_valid),
    .ratio_err  (ratio_err),
    .duty_err   (duty_err),
    .locked     (locked),
    .state_dbg  (state_dbg)
`ifdef CLKMON_TIMEOUT_EN
    ,
    .stuck      (stuck_s)
`endif
  );
`ifndef CLKMON_TIMEOUT_EN
  assign stuck_s = 1'b0;
`endif

  int tests = 0;
  int errors = 0;

  // ---------------- clk_div driver ----------------
  int drv_p = 7, drv_h = 4;
  bit drv_hold = 1, drv_hold_val = 0;
  int cur_p, cur_h;

  // Each period is read from the config at its start, so changes apply at period boundaries.
  initial begin
    forever begin
      if (drv_hold) begin
        @(posedge clk); #1 clk_div = drv_hold_val;
      end else begin
        cur_p = drv_p;
        cur_h = drv_h;
        for (int i = 0; i < cur_p; i++) begin
          @(posedge clk); #1 clk_div = (i < cur_h);
        end
      end
    end
  end

  task automatic set_div(input int p, input int h);
    drv_p = p; drv_h = h; drv_hold = 0;
  endtask

  // ---------------- reference model ----------------
  // Works on the sampled waveform: a rise at sample k is seen LAT edges later; the first
  // seen rise arms, every later one reports distance and ones-count since the previous rise.
  bit samp[$];
  int pend[$];
  int n, last_r, last_evt, good, r, per, hi;
  bit armed;
  logic [CNT_W-1:0] exp_period, exp_high;
  bit exp_mv, exp_ratio, exp_duty, exp_locked, exp_stuck;

  always @(posedge clk) begin
    if (!rstn) begin
      samp.delete(); pend.delete();
      n = 0; armed = 0; good = 0; last_r = 0; last_evt = 0;
      exp_period = 0; exp_high = 0; exp_mv = 0;
      exp_ratio = 0; exp_duty = 0; exp_locked = 0; exp_stuck = 0;
    end else begin
      exp_mv = 0;
      if (clk_div && (n == 0 || !samp[n-1])) pend.push_back(n);
      samp.push_back(clk_div);
      if (pend.size() > 0 && pend[0] + LAT == n) begin
        r = pend.pop_front();
        if (armed) begin
          per = r - last_r;
          hi = 0;
          for (int i = last_r; i < r; i++) hi += int'(samp[i]);
          if (per > SAT) per = SAT;
          if (hi > SAT) hi = SAT;
          exp_mv = 1;
          exp_period = CNT_W'(per);
          exp_high = CNT_W'(hi);
          exp_ratio = (per != DIV_EXP);
          exp_duty = (hi != DIV_EXP / 2) && (hi != (DIV_EXP + 1) / 2);
          exp_stuck = 0;
          if (exp_ratio || exp_duty) good = 0;
          else if (good < LOCK_CNT) good++;
          exp_locked = (good == LOCK_CNT);
        end
        armed = 1;
        last_r = r;
        last_evt = n;
`ifdef CLKMON_TIMEOUT_EN
      end else if (armed && (n - last_evt) == TMO) begin
        armed = 0; exp_stuck = 1; exp_locked = 0; good = 0;
`endif
      end
      n++;
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    tests++;
    if ({period_cnt, high_cnt, meas_valid, ratio_err, duty_err, locked, stuck_s} !==
        {exp_period, exp_high, exp_mv, exp_ratio, exp_duty, exp_locked, exp_stuck}) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t got per=%0d hi=%0d mv=%0b re=%0b de=%0b lk=%0b st=%0b want per=%0d hi=%0d mv=%0b re=%0b de=%0b lk=%0b st=%0b",
               $time, period_cnt, high_cnt, meas_valid, ratio_err, duty_err, locked, stuck_s,
               exp_period, exp_high, exp_mv, exp_ratio, exp_duty, exp_locked, exp_stuck);
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi_b);
    tests++;
    if (act < lo || act > hi_b) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi_b);
    end
  endtask

  task automatic wait_meas(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = meas_valid;
    end
    tests++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_meas: got no meas_valid expected one within %0d cycles", budget);
    end
  endtask

  task automatic wait_locked();
    for (int i = 0; i < 8 && !locked; i++) wait_meas(40);
    check("lock_reached", int'(locked), 1);
  endtask

  task automatic pulse_reset(input int hold);
    @(negedge clk); #2 rstn = 0; #1;
    check("rst_async_outputs",
          int'({period_cnt, high_cnt, meas_valid, ratio_err, duty_err, locked, stuck_s}), 0);
    repeat (hold) @(negedge clk);
    #2 rstn = 1;
  endtask

  // ---------------- main sequence ----------------
  int k, mv_cnt, p;
  bit changed;
  logic [2*CNT_W+2:0] snap;

  initial begin
    repeat (2) @(negedge clk);
    #2 rstn = 1;
    @(negedge clk);
    check("reset_state",
          int'({period_cnt, high_cnt, meas_valid, ratio_err, duty_err, locked, stuck_s}), 0);

    // Nominal divide-by-7: lock on the 4th measurement.
    set_div(7, 4);
    for (int i = 0; i < 4; i++) begin
      wait_meas(40);
      check("nom_period", int'(period_cnt), 7);
      check("nom_high", int'(high_cnt), 4);
      check("nom_errs", int'({ratio_err, duty_err}), 0);
      check("nom_locked", int'(locked), (i == 3) ? 1 : 0);
    end

    // Switch to divide-by-6: the period in flight still reports 7, the next one 6.
    set_div(6, 3);
    wait_meas(40);
    wait_meas(40);
    check("div6_period", int'(period_cnt), 6);
    check("div6_ratio_err", int'(ratio_err), 1);
    check("div6_unlocked", int'(locked), 0);
    set_div(7, 4);
    wait_meas(40);
    check("div6_tail_ratio_err", int'(ratio_err), 1);
    for (int i = 0; i < 4; i++) begin
      wait_meas(40);
      check("relock_locked", int'(locked), (i == 3) ? 1 : 0);
    end

    // One-cycle-high waveform: duty error only.
    set_div(7, 1);
    wait_meas(40);
    wait_meas(40);
    check("duty_high", int'(high_cnt), 1);
    check("duty_err", int'(duty_err), 1);
    check("duty_ratio_ok", int'(ratio_err), 0);
    check("duty_unlocked", int'(locked), 0);
    wait_meas(40);
    check("duty_still_unlocked", int'(locked), 0);

    // Reset mid-period while locked: first report needs two post-reset rises.
    set_div(7, 4);
    wait_locked();
    repeat (3) @(negedge clk);
    pulse_reset(3);
    k = 0;
    while (!meas_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    check_range("post_reset_first_meas", k, 11, 17);
    check("post_reset_period", int'(period_cnt), 7);

    // Stop clk_div after lock.
    wait_locked();
    wait_meas(40);
    drv_hold_val = 0;
    drv_hold = 1;
`ifdef CLKMON_TIMEOUT_EN
    k = 0;
    while (!stuck_s && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycles", k, TMO);
    check("timeout_unlocked", int'(locked), 0);
    check("timeout_period_held", int'(period_cnt), 7);
    set_div(7, 4);
    wait_meas(40);
    check("stuck_cleared", int'(stuck_s), 0);
`else
    snap = {period_cnt, high_cnt, ratio_err, duty_err, locked};
    mv_cnt = 0;
    changed = 0;
    repeat (1000) begin
      @(negedge clk);
      if (meas_valid) mv_cnt++;
      if ({period_cnt, high_cnt, ratio_err, duty_err, locked} != snap) changed = 1;
    end
    check("hold_no_meas", mv_cnt, 0);
    check("hold_outputs_stable", int'(changed), 0);
    check("hold_still_locked", int'(locked), 1);
    set_div(7, 4);
`endif

    // Randomized segments: nominal, arbitrary, held, or reset.
    for (int seg = 0; seg < 30; seg++) begin
      k = $urandom_range(0, 9);
      if (k < 5) begin
        set_div(7, $urandom_range(3, 4));
      end else if (k < 8) begin
        p = $urandom_range(2, 20);
        set_div(p, $urandom_range(0, p));
      end else if (k == 8) begin
        drv_hold_val = 1'($urandom_range(0, 1));
        drv_hold = 1;
        repeat ($urandom_range(40, 300)) @(negedge clk);
        set_div(7, 4);
      end else begin
        pulse_reset($urandom_range(1, 4));
      end
      repeat ($urandom_range(20, 200)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #5ms;
    $display("FAIL watchdog: got no completion expected finish before 5ms");
    $fatal(1, "watchdog");
  end

endmodule
